instruction_decode_stage: RTL and testbench
===========================================

# instruction_decode_stage

RV32I decode stage sitting between instruction fetch and execute, directly upstream of `Register_File`. It drives the register file read addresses from the incoming instruction and decodes opcode, fields and immediate. It captures operands into an ID/EX pipeline register with a valid/ready handshake. It also forwards same-cycle write-back data and inserts a one-cycle bubble on load-use hazards.

## Interface
- No parameters.
- `pll_1_200MHz`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous pipeline flush from branch/jump resolution.
- `if_valid`  in  1  fetch presents an instruction.
- `if_ready`  out  1  decode accepts the instruction this cycle.
- `if_instr`  in  32  instruction word.
- `if_pc`  in  32  instruction address.
- `rf_read_reg1` / `rf_read_reg2`  out  5  register file read addresses: `if_instr[19:15]` / `if_instr[24:20]`, combinational.
- `rf_read_data1` / `rf_read_data2`  in  32  register file combinational read data.
- `wb_write_enable`, `wb_write_reg[4:0]`, `wb_write_data[31:0]`  in  write-back port, also wired to the register file write port.
- `ex_valid`  out  1  ID/EX register holds a valid instruction.
- `ex_ready`  in  1  execute consumes the ID/EX contents this cycle.
- `ex_pc` (32), `ex_rs1_data` (32), `ex_rs2_data` (32), `ex_imm` (32)  out  registered operands.
- `ex_rd` (5), `ex_opcode` (7), `ex_funct3` (3), `ex_funct7_b5` (1)  out  registered fields.
- `ex_rd_write`, `ex_is_load`, `ex_illegal`  out  1  registered control flags.

## Operation
- Field decode: rs1=[19:15], rs2=[24:20], rd=[11:7], funct3=[14:12], funct7_b5=[30], opcode=[6:0].
- Immediates, sign-extended from bit 31:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
- Format by opcode:
  - I: LOAD 0000011, OP-IMM 0010011, JALR 1100111, SYSTEM 1110011, FENCE 0001111.
  - S: STORE 0100011.
  - B: BRANCH 1100011.
  - U: LUI 0110111, AUIPC 0010111.
  - J: JAL 1101111.
  - None: OP 0110011; `ex_imm`=0.
- Any other opcode sets `ex_illegal`=1, `ex_rd_write`=0 and `ex_imm`=0.
- `ex_rd_write`=1 only for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP, and only when rd != 0.
- `ex_is_load`=1 only for LOAD.
- Register usage:
  - rs1 is used by JALR, BRANCH, LOAD, STORE, OP-IMM and OP.
  - rs2 is used by BRANCH, STORE and OP.
- Forwarding: the captured rsN data is `wb_write_data` when `wb_write_enable` && `wb_write_reg`==rsN && rsN!=0. Otherwise it is `rf_read_dataN`. Register x0 always yields 0.
- Load-use hazard = `ex_valid` && `ex_is_load` && `ex_rd`!=0 && (`ex_rd` matches a used rs1 or rs2 of `if_instr`) && `if_valid`.
- `advance` = !`ex_valid` || `ex_ready`.
- `if_ready` = `advance` && !hazard, or 1 when `flush`=1.
- Per cycle, in priority order:
  - `reset`: `ex_valid`←0 and all `ex_*` outputs ←0.
  - `flush`: `ex_valid`←0; any offered instruction is discarded.
  - `advance` && hazard: bubble, `ex_valid`←0; the instruction stays at fetch.
  - `advance` && `if_valid`: load the ID/EX register, `ex_valid`←1.
  - `advance` && !`if_valid`: `ex_valid`←0.
  - Otherwise: hold all `ex_*` unchanged.

## Timing
- Decode latency is 1 cycle: an instruction accepted at edge N appears on `ex_*` after edge N.
- Register file reads are combinational in the same cycle; the write-back bypass covers the write landing on that same edge.
- A load-use hazard costs exactly one bubble cycle; the dependent instruction is accepted on the following edge.
- While `ex_valid`=1 && `ex_ready`=0, all `ex_*` outputs stay stable.
- Reset or flush asserted mid-stall clears the stall; no instruction is duplicated or lost apart from the flushed one.
- A simultaneous `reset` and `flush` behaves as `reset`.

## Test plan
- Reset, then `if_instr`=32'h00500093 (addi x1,x0,5) → `ex_rd`=1, `ex_imm`=5, `ex_rs1_data`=0, `ex_rd_write`=1, one cycle later.
- Write-back x5=32'hFFFFFFFF in the same cycle as decoding add x6,x5,x5 → `ex_rs1_data`=`ex_rs2_data`=32'hFFFFFFFF.
- lw x2,0(x1), then add x3,x2,x2 → one cycle with `ex_valid`=0 and `if_ready`=0; the add is issued on the next edge.
- Branch 32'hFE000EE3 (beq x0,x0,-4) → `ex_imm`=32'hFFFFFFFC; jal 32'h008000EF → `ex_imm`=8, `ex_rd`=1.
- Hold `ex_ready`=0 for 3 cycles → `ex_*` outputs unchanged and `if_ready`=0; assert `flush` → `ex_valid`=0 next cycle.
- `if_instr`=32'h0000007F → `ex_illegal`=1, `ex_rd_write`=0; addi writing x0 → `ex_rd_write`=0.

Source files
------------

// File: rtl/instruction_decode_stage_if.sv
// Bundle of fetch, register-file, write-back and execute-side signals around the decode stage.
// Latency: none (wires only).
// Backpressure: carries if_valid/if_ready towards fetch and ex_valid/ex_ready towards execute.
interface instruction_decode_stage_if;
    logic        flush;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [4:0]  rf_read_reg1;
    logic [4:0]  rf_read_reg2;
    logic [31:0] rf_read_data1;
    logic [31:0] rf_read_data2;
    logic        wb_write_enable;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1_data;
    logic [31:0] ex_rs2_data;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rd;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic        ex_funct7_b5;
    logic        ex_rd_write;
    logic        ex_is_load;
    logic        ex_illegal;

    // Decode stage side: drives fetch ready, register-file addresses and the ID/EX outputs.
    modport master (
        input  flush, if_valid, if_instr, if_pc,
        input  rf_read_data1, rf_read_data2,
        input  wb_write_enable, wb_write_reg, wb_write_data,
        input  ex_ready,
        output if_ready, rf_read_reg1, rf_read_reg2,
        output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
        output ex_rd, ex_opcode, ex_funct3, ex_funct7_b5,
        output ex_rd_write, ex_is_load, ex_illegal
    );

    // Surrounding pipeline side: fetch, register file, write-back and execute.
    modport slave (
        output flush, if_valid, if_instr, if_pc,
        output rf_read_data1, rf_read_data2,
        output wb_write_enable, wb_write_reg, wb_write_data,
        output ex_ready,
        input  if_ready, rf_read_reg1, rf_read_reg2,
        input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
        input  ex_rd, ex_opcode, ex_funct3, ex_funct7_b5,
        input  ex_rd_write, ex_is_load, ex_illegal
    );
endinterface

// File: rtl/instruction_decode_stage.sv
// RV32I decode: field/immediate decode, write-back bypass, load-use bubble, ID/EX register.
// Latency: 1 cycle from acceptance (if_valid && if_ready) to ex_* outputs.
// Backpressure: if_ready drops while ID/EX is held (ex_ready=0) or during a load-use bubble; flush always accepts and drops.
module instruction_decode_stage (
    input  logic pll_1_200MHz,
    input  logic reset,
    instruction_decode_stage_if.master dec_if
);
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7_b5;
        logic        rd_write;
        logic        is_load;
        logic        illegal;
    } idex_t;

    idex_t       r_idex;
    idex_t       w_dec;
    logic [31:0] w_instr;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic [6:0]  w_opcode;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm;
    logic        w_legal;
    logic        w_writes_rd;
    logic        w_is_load;
    logic        w_uses_rs1;
    logic        w_uses_rs2;
    logic [31:0] w_rs1_data;
    logic [31:0] w_rs2_data;
    logic        w_hazard;
    logic        w_advance;

    assign w_instr  = dec_if.if_instr;
    assign w_rs1    = w_instr[19:15];
    assign w_rs2    = w_instr[24:20];
    assign w_rd     = w_instr[11:7];
    assign w_opcode = w_instr[6:0];

    assign dec_if.rf_read_reg1 = w_rs1;
    assign dec_if.rf_read_reg2 = w_rs2;

    assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
    assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
    assign w_imm_u = {w_instr[31:12], 12'b0};
    assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};

    // Classify the opcode: immediate format, register usage and control flags.
    always_comb begin
        w_imm       = '0;
        w_legal     = 1'b1;
        w_writes_rd = 1'b0;
        w_is_load   = 1'b0;
        w_uses_rs1  = 1'b0;
        w_uses_rs2  = 1'b0;
        case (w_opcode)
            OPC_LOAD: begin
                w_imm       = w_imm_i;
                w_writes_rd = 1'b1;
                w_is_load   = 1'b1;
                w_uses_rs1  = 1'b1;
            end
            OPC_OPIMM, OPC_JALR: begin
                w_imm       = w_imm_i;
                w_writes_rd = 1'b1;
                w_uses_rs1  = 1'b1;
            end
            OPC_SYSTEM, OPC_FENCE: begin
                w_imm = w_imm_i;
            end
            OPC_STORE: begin
                w_imm      = w_imm_s;
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
            end
            OPC_BRANCH: begin
                w_imm      = w_imm_b;
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                w_imm       = w_imm_u;
                w_writes_rd = 1'b1;
            end
            OPC_JAL: begin
                w_imm       = w_imm_j;
                w_writes_rd = 1'b1;
            end
            OPC_OP: begin
                w_writes_rd = 1'b1;
                w_uses_rs1  = 1'b1;
                w_uses_rs2  = 1'b1;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    // x0 reads as zero; a write-back landing on this edge overrides the stale register-file value.
    assign w_rs1_data = (w_rs1 == 5'd0) ? 32'd0 :
                        (dec_if.wb_write_enable && (dec_if.wb_write_reg == w_rs1)) ? dec_if.wb_write_data :
                        dec_if.rf_read_data1;
    assign w_rs2_data = (w_rs2 == 5'd0) ? 32'd0 :
                        (dec_if.wb_write_enable && (dec_if.wb_write_reg == w_rs2)) ? dec_if.wb_write_data :
                        dec_if.rf_read_data2;

    // A load in ID/EX cannot feed a dependent instruction in the same cycle; hold it at fetch one cycle.
    assign w_hazard  = dec_if.if_valid && r_idex.valid && r_idex.is_load && (r_idex.rd != 5'd0) &&
                       ((w_uses_rs1 && (w_rs1 == r_idex.rd)) || (w_uses_rs2 && (w_rs2 == r_idex.rd)));
    assign w_advance = !r_idex.valid || dec_if.ex_ready;

    assign dec_if.if_ready = dec_if.flush || (w_advance && !w_hazard);

    // Assemble the ID/EX record for the instruction currently offered by fetch.
    always_comb begin
        w_dec           = '0;
        w_dec.valid     = 1'b1;
        w_dec.pc        = dec_if.if_pc;
        w_dec.rs1_data  = w_rs1_data;
        w_dec.rs2_data  = w_rs2_data;
        w_dec.imm       = w_imm;
        w_dec.rd        = w_rd;
        w_dec.opcode    = w_opcode;
        w_dec.funct3    = w_instr[14:12];
        w_dec.funct7_b5 = w_instr[30];
        w_dec.rd_write  = w_writes_rd && (w_rd != 5'd0);
        w_dec.is_load   = w_is_load;
        w_dec.illegal   = !w_legal;
    end

    // ID/EX register: reset > flush > bubble > load > drain > hold.
    always_ff @(posedge pll_1_200MHz) begin
        if (reset) begin
            r_idex <= '0;
        end else if (dec_if.flush) begin
            r_idex.valid <= 1'b0;
        end else if (w_advance) begin
            if (w_hazard || !dec_if.if_valid) begin
                r_idex.valid <= 1'b0;
            end else begin
                r_idex <= w_dec;
            end
        end
    end

    assign dec_if.ex_valid     = r_idex.valid;
    assign dec_if.ex_pc        = r_idex.pc;
    assign dec_if.ex_rs1_data  = r_idex.rs1_data;
    assign dec_if.ex_rs2_data  = r_idex.rs2_data;
    assign dec_if.ex_imm       = r_idex.imm;
    assign dec_if.ex_rd        = r_idex.rd;
    assign dec_if.ex_opcode    = r_idex.opcode;
    assign dec_if.ex_funct3    = r_idex.funct3;
    assign dec_if.ex_funct7_b5 = r_idex.funct7_b5;
    assign dec_if.ex_rd_write  = r_idex.rd_write;
    assign dec_if.ex_is_load   = r_idex.is_load;
    assign dec_if.ex_illegal   = r_idex.illegal;
endmodule

// File: tb/tb_instruction_decode_stage.sv
// Bench for instruction_decode_stage: directed vector table, hand-written stall/hazard sequences, random run vs reference model.
// Latency: checks ex_* one cycle after acceptance.
// Backpressure: drives ex_ready/flush randomly and checks if_ready each cycle.
module tb_instruction_decode_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instruction_decode_stage_if dif();

    instruction_decode_stage dut (
        .pll_1_200MHz(clk),
        .reset       (reset),
        .dec_if      (dif)
    );

    // Register file stand-in; x0 deliberately holds garbage so the stage's own x0 rule is exercised.
    logic [31:0] regs [32];
    assign dif.rf_read_data1 = regs[dif.rf_read_reg1];
    assign dif.rf_read_data2 = regs[dif.rf_read_reg2];

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic        rdw;
        logic        ld;
        logic        ill;
    } ex_t;

    ex_t act;
    assign act = {dif.ex_valid, dif.ex_pc, dif.ex_rs1_data, dif.ex_rs2_data, dif.ex_imm, dif.ex_rd,
                  dif.ex_opcode, dif.ex_funct3, dif.ex_funct7_b5, dif.ex_rd_write, dif.ex_is_load, dif.ex_illegal};

    int checks = 0;
    int errors = 0;

    task automatic chk32(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic chk_ex(input string nm, input ex_t a, input ex_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] sx(input longint v, input int bits);
        longint half;
        longint r;
        half = longint'(1) << (bits - 1);
        r = (v >= half) ? v - 2 * half : v;
        return r[31:0];
    endfunction

    function automatic logic uses1(input logic [6:0] op);
        return op inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    endfunction

    function automatic logic uses2(input logic [6:0] op);
        return op inside {7'h63, 7'h23, 7'h33};
    endfunction

    function automatic logic [31:0] opnd(input logic [4:0] r, input logic we, input logic [4:0] wr,
                                         input logic [31:0] wd);
        if (r == 5'd0) return 32'd0;
        if (we && wr == r) return wd;
        return regs[r];
    endfunction

    function automatic ex_t ref_decode(input logic [31:0] ins, input logic [31:0] pc, input logic we,
                                       input logic [4:0] wr, input logic [31:0] wd);
        ex_t    e;
        longint w;
        longint u;
        int     fmt; // -1 illegal, 0 none, 1 I, 2 S, 3 B, 4 U, 5 J
        w = {32'b0, ins};
        e = '0;
        e.valid = 1'b1;
        e.pc    = pc;
        e.rd    = ins[11:7];
        e.opc   = ins[6:0];
        e.f3    = ins[14:12];
        e.f7    = ins[30];
        e.rs1d  = opnd(ins[19:15], we, wr, wd);
        e.rs2d  = opnd(ins[24:20], we, wr, wd);
        case (ins[6:0])
            7'h03, 7'h13, 7'h67, 7'h73, 7'h0F: fmt = 1;
            7'h23: fmt = 2;
            7'h63: fmt = 3;
            7'h37, 7'h17: fmt = 4;
            7'h6F: fmt = 5;
            7'h33: fmt = 0;
            default: fmt = -1;
        endcase
        case (fmt)
            1: e.imm = sx(w >> 20, 12);
            2: e.imm = sx((w >> 25) * 32 + ((w >> 7) % 32), 12);
            3: e.imm = sx(((w >> 31) % 2) * 4096 + ((w >> 7) % 2) * 2048 + ((w >> 25) % 64) * 32
                          + ((w >> 8) % 16) * 2, 13);
            4: begin
                u = (w >> 12) * 4096;
                e.imm = u[31:0];
            end
            5: e.imm = sx((w >> 31) * 1048576 + ((w >> 12) % 256) * 4096 + ((w >> 20) % 2) * 2048
                          + ((w >> 21) % 1024) * 2, 21);
            default: e.imm = 32'd0;
        endcase
        e.ill = (fmt < 0);
        e.ld  = (ins[6:0] == 7'h03);
        e.rdw = (ins[6:0] inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33}) && (ins[11:7] != 5'd0);
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] ins;
        logic [6:0]  ops [12];
        int          k;
        ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
        k = $urandom_range(0, 14);
        ins = $urandom;
        if (k >= 12) ins[6:0] = 7'h03;
        else if (k == 11) ins[6:0] = ($urandom_range(0, 1) == 0) ? 7'h7F : 7'h0B;
        else ins[6:0] = ops[k];
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        ins[11:7]  = 5'($urandom_range(0, 7));
        return ins;
    endfunction

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rdw;
        logic        ill;
        logic        ld;
    } vec_t;

    localparam int NV = 13;
    vec_t tbl [NV];

    task automatic idle_inputs();
        dif.flush = 1'b0;
        dif.if_valid = 1'b0;
        dif.if_instr = 32'h0000_0013;
        dif.if_pc = 32'd0;
        dif.wb_write_enable = 1'b0;
        dif.wb_write_reg = 5'd0;
        dif.wb_write_data = 32'd0;
        dif.ex_ready = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    ex_t         m;
    ex_t         mn;
    ex_t         snap;
    logic        hz;
    logic        adv;
    logic [31:0] e32;

    initial begin
        tbl[0]  = '{32'h00500093, 32'h00000005, 5'd1,  1'b1, 1'b0, 1'b0}; // addi x1,x0,5
        tbl[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 5'd29, 1'b0, 1'b0, 1'b0}; // beq x0,x0,-4
        tbl[2]  = '{32'h008000EF, 32'h00000008, 5'd1,  1'b1, 1'b0, 1'b0}; // jal x1,8
        tbl[3]  = '{32'h0000007F, 32'h00000000, 5'd0,  1'b0, 1'b1, 1'b0}; // illegal opcode
        tbl[4]  = '{32'h00100013, 32'h00000001, 5'd0,  1'b0, 1'b0, 1'b0}; // addi x0,x0,1
        tbl[5]  = '{32'h123452B7, 32'h12345000, 5'd5,  1'b1, 1'b0, 1'b0}; // lui x5
        tbl[6]  = '{32'hFE20AC23, 32'hFFFFFFF8, 5'd24, 1'b0, 1'b0, 1'b0}; // sw x2,-8(x1)
        tbl[7]  = '{32'h0000A103, 32'h00000000, 5'd2,  1'b1, 1'b0, 1'b1}; // lw x2,0(x1)
        tbl[8]  = '{32'h002101B3, 32'h00000000, 5'd3,  1'b1, 1'b0, 1'b0}; // add x3,x2,x2
        tbl[9]  = '{32'hFFFFF397, 32'hFFFFF000, 5'd7,  1'b1, 1'b0, 1'b0}; // auipc x7
        tbl[10] = '{32'hFFF100E7, 32'hFFFFFFFF, 5'd1,  1'b1, 1'b0, 1'b0}; // jalr x1,-1(x2)
        tbl[11] = '{32'h00000073, 32'h00000000, 5'd0,  1'b0, 1'b0, 1'b0}; // ecall
        tbl[12] = '{32'h0FF0000F, 32'h000000FF, 5'd0,  1'b0, 1'b0, 1'b0}; // fence

        for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
        regs[0] = 32'hDEADBEEF;
        idle_inputs();
        dif.if_valid = 1'b1;
        dif.if_instr = 32'h00500093;
        reset = 1'b1;
        tick();
        tick();
        chk_ex("reset_state", act, '0);
        dif.if_valid = 1'b0;
        reset = 1'b0;
        chk32("reset_if_ready", 32'(dif.if_ready), 32'd1);

        // Directed table, one instruction at a time with an idle cycle between.
        for (int k = 0; k < NV; k++) begin
            dif.if_instr = tbl[k].instr;
            dif.if_pc = 32'h100 + 32'(k) * 4;
            dif.if_valid = 1'b1;
            tick();
            dif.if_valid = 1'b0;
            chk32("vec_valid", 32'(dif.ex_valid), 32'd1);
            chk32("vec_imm", dif.ex_imm, tbl[k].imm);
            chk32("vec_flags", {24'd0, dif.ex_rd, dif.ex_rd_write, dif.ex_illegal, dif.ex_is_load},
                  {24'd0, tbl[k].rd, tbl[k].rdw, tbl[k].ill, tbl[k].ld});
            e32 = (tbl[k].instr[19:15] == 5'd0) ? 32'd0 : regs[tbl[k].instr[19:15]];
            chk32("vec_rs1_data", dif.ex_rs1_data, e32);
            chk32("vec_pc", dif.ex_pc, 32'h100 + 32'(k) * 4);
            tick();
        end

        // Write-back bypass: x5 written on the same edge the add is decoded.
        dif.if_instr = 32'h00528333;
        dif.if_valid = 1'b1;
        dif.wb_write_enable = 1'b1;
        dif.wb_write_reg = 5'd5;
        dif.wb_write_data = 32'hFFFFFFFF;
        tick();
        regs[5] = 32'hFFFFFFFF;
        chk32("fwd_rs1", dif.ex_rs1_data, 32'hFFFFFFFF);
        chk32("fwd_rs2", dif.ex_rs2_data, 32'hFFFFFFFF);
        // Write-back to x0 must not leak into an x0 operand.
        dif.if_instr = 32'h00000333;
        dif.wb_write_reg = 5'd0;
        dif.wb_write_data = 32'h12345678;
        tick();
        chk32("x0_rs1", dif.ex_rs1_data, 32'd0);
        chk32("x0_rs2", dif.ex_rs2_data, 32'd0);
        idle_inputs();
        tick();

        // Load-use: lw x2 then add x3,x2,x2 -> one bubble.
        dif.if_instr = 32'h0000A103;
        dif.if_valid = 1'b1;
        tick();
        dif.if_instr = 32'h002101B3;
        #1;
        chk32("lu_if_ready_stall", 32'(dif.if_ready), 32'd0);
        tick();
        chk32("lu_bubble_valid", 32'(dif.ex_valid), 32'd0);
        chk32("lu_if_ready_after", 32'(dif.if_ready), 32'd1);
        tick();
        dif.if_valid = 1'b0;
        chk32("lu_issue_valid", 32'(dif.ex_valid), 32'd1);
        chk32("lu_issue_rd", 32'(dif.ex_rd), 32'd3);
        tick();

        // Backpressure for 3 cycles, then flush.
        dif.if_instr = 32'h008000EF;
        dif.if_valid = 1'b1;
        tick();
        snap = act;
        dif.ex_ready = 1'b0;
        dif.if_instr = 32'h00500093;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk32("stall_if_ready", 32'(dif.if_ready), 32'd0);
            tick();
            chk_ex("stall_hold", act, snap);
        end
        dif.flush = 1'b1;
        #1;
        chk32("flush_if_ready", 32'(dif.if_ready), 32'd1);
        tick();
        dif.flush = 1'b0;
        dif.if_valid = 1'b0;
        chk32("flush_valid", 32'(dif.ex_valid), 32'd0);
        dif.ex_ready = 1'b1;

        // Simultaneous reset and flush behaves as reset (all outputs cleared).
        dif.if_instr = 32'h123452B7;
        dif.if_valid = 1'b1;
        tick();
        dif.if_valid = 1'b0;
        reset = 1'b1;
        dif.flush = 1'b1;
        tick();
        reset = 1'b0;
        dif.flush = 1'b0;
        chk_ex("reset_flush", act, '0);

        // Randomized run against the reference model.
        m = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset = ($urandom_range(0, 99) < 2);
            dif.flush = ($urandom_range(0, 15) == 0);
            dif.if_valid = ($urandom_range(0, 3) != 0);
            dif.ex_ready = ($urandom_range(0, 3) != 0);
            dif.if_instr = gen_instr();
            dif.if_pc = $urandom;
            dif.wb_write_enable = ($urandom_range(0, 1) == 1);
            dif.wb_write_reg = 5'($urandom_range(0, 7));
            dif.wb_write_data = $urandom;
            @(negedge clk);
            hz = m.valid && m.ld && (m.rd != 5'd0) && dif.if_valid &&
                 ((uses1(dif.if_instr[6:0]) && dif.if_instr[19:15] == m.rd) ||
                  (uses2(dif.if_instr[6:0]) && dif.if_instr[24:20] == m.rd));
            adv = !m.valid || dif.ex_ready;
            chk_ex("rand_ex", act, m);
            chk32("rand_if_ready", 32'(dif.if_ready), 32'(dif.flush || (adv && !hz)));
            chk32("rand_rf_addr", {22'd0, dif.rf_read_reg1, dif.rf_read_reg2},
                  {22'd0, dif.if_instr[19:15], dif.if_instr[24:20]});
            mn = m;
            if (reset) mn = '0;
            else if (dif.flush) mn.valid = 1'b0;
            else if (adv) begin
                if (hz || !dif.if_valid) mn.valid = 1'b0;
                else mn = ref_decode(dif.if_instr, dif.if_pc, dif.wb_write_enable, dif.wb_write_reg,
                                     dif.wb_write_data);
            end
            tick();
            if (dif.wb_write_enable && dif.wb_write_reg != 5'd0) regs[dif.wb_write_reg] = dif.wb_write_data;
            m = mn;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
